// File: rtl/hv_addr_pkg.sv
// Shared types for the nested item-memory address generator and its CSR decoder.
package hv_addr_pkg;

    localparam int unsigned DefCsrDataWidth = 32;
    localparam int unsigned DefNumTotIm     = 1024;
    localparam int unsigned DefImAddrWidth  = $clog2(DefNumTotIm);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [DefImAddrWidth-1:0]  addr_t;
    typedef logic [DefCsrDataWidth-1:0] csr_data_t;

    typedef struct packed {
        csr_data_t start_addr;
        csr_data_t inner_count;
        csr_data_t inner_stride;
        csr_data_t outer_count;
        csr_data_t outer_stride;
    } cfg_t;

    // Index of the last iteration; a trip count of 0 behaves like 1.
    function automatic csr_data_t last_index(input csr_data_t count);
        return (count == '0) ? '0 : count - DefCsrDataWidth'(1);
    endfunction

endpackage

// File: rtl/loop_counter.sv
// One loop level: trip counter with last-iteration flag and wrap pulse.
module loop_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             en,
    input  logic [Width-1:0] max_count,
    output logic             last_c,
    output logic             wrap_c
);

    logic [Width-1:0] count_q;

    assign last_c = (count_q == max_count);
    assign wrap_c = en & last_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr || wrap_c) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + Width'(1);
        end
    end

endmodule

// File: rtl/nested_addr_counter.sv
// Two-level strided address generator for item-memory fetch.
// Optional build macro NESTED_ADDR_COUNTER_REPEAT_EN adds repeat_i (auto-restart until clr_i).
module nested_addr_counter
    import hv_addr_pkg::*;
#(
    parameter int unsigned CsrDataWidth = DefCsrDataWidth,
    parameter int unsigned NumTotIm     = DefNumTotIm
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          clr_i,
    input  logic [CsrDataWidth-1:0]       start_addr_i,
    input  logic [CsrDataWidth-1:0]       inner_count_i,
    input  logic [CsrDataWidth-1:0]       inner_stride_i,
    input  logic [CsrDataWidth-1:0]       outer_count_i,
    input  logic [CsrDataWidth-1:0]       outer_stride_i,
`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
    input  logic                          repeat_i,
`endif
    output logic [$clog2(NumTotIm)-1:0]   addr_o,
    output logic                          addr_valid_o,
    input  logic                          addr_ready_i,
    output logic                          last_inner_o,
    output logic                          last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned ImAddrWidth = $clog2(NumTotIm);

    state_e                 state_q, state_d;
    cfg_t                   cfg_q, cfg_in;
    logic [ImAddrWidth-1:0] addr_q, addr_d, row_q, row_d;
    logic [ImAddrWidth-1:0] inner_stride_c, outer_stride_c, start_c;
    logic                   done_q, done_d;
    logic                   repeat_q;
    logic                   start_acc_c, step_c, clr_cnt_c;
    logic                   inner_last_c, inner_wrap_c, outer_last_c, outer_wrap_c;
    logic                   unused_cfg;

    assign cfg_in = '{start_addr:   start_addr_i,
                      inner_count:  inner_count_i,
                      inner_stride: inner_stride_i,
                      outer_count:  outer_count_i,
                      outer_stride: outer_stride_i};

    assign inner_stride_c = cfg_q.inner_stride[ImAddrWidth-1:0];
    assign outer_stride_c = cfg_q.outer_stride[ImAddrWidth-1:0];
    assign start_c        = cfg_q.start_addr[ImAddrWidth-1:0];
    assign unused_cfg     = ^{cfg_q.start_addr[CsrDataWidth-1:ImAddrWidth],
                              cfg_q.inner_stride[CsrDataWidth-1:ImAddrWidth],
                              cfg_q.outer_stride[CsrDataWidth-1:ImAddrWidth]};

    // clr_i kills any same-cycle transfer
    assign step_c    = (state_q == RUN) & addr_ready_i & ~clr_i;
    assign clr_cnt_c = clr_i | start_acc_c;

    loop_counter #(.Width(CsrDataWidth)) u_inner (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr       (clr_cnt_c),
        .en        (step_c),
        .max_count (last_index(cfg_q.inner_count)),
        .last_c    (inner_last_c),
        .wrap_c    (inner_wrap_c)
    );

    loop_counter #(.Width(CsrDataWidth)) u_outer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr       (clr_cnt_c),
        .en        (inner_wrap_c),
        .max_count (last_index(cfg_q.outer_count)),
        .last_c    (outer_last_c),
        .wrap_c    (outer_wrap_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            if (start_acc_c) begin
                cfg_q <= cfg_in;
            end
        end
    end

`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            repeat_q <= 1'b0;
        end else if (start_acc_c) begin
            repeat_q <= repeat_i;
        end
    end
`else
    assign repeat_q = 1'b0;
`endif

    // Next state: outer wrap is the final handshake of the sequence
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        start_acc_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!clr_i && start_i) begin
                    state_d     = RUN;
                    start_acc_c = 1'b1;
                end
            end
            RUN: begin
                if (clr_i) begin
                    state_d = IDLE;
                end else if (outer_wrap_c) begin
                    done_d = 1'b1;
                    if (!repeat_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator datapath: row base steps by outer stride, address by inner stride
    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        if (clr_i) begin
            addr_d = '0;
            row_d  = '0;
        end else if (start_acc_c) begin
            addr_d = start_addr_i[ImAddrWidth-1:0];
            row_d  = start_addr_i[ImAddrWidth-1:0];
        end else if (outer_wrap_c) begin
            addr_d = start_c;
            row_d  = start_c;
        end else if (inner_wrap_c) begin
            addr_d = row_q + outer_stride_c;
            row_d  = row_q + outer_stride_c;
        end else if (step_c) begin
            addr_d = addr_q + inner_stride_c;
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = (state_q == RUN);
    assign busy_o       = (state_q == RUN);
    assign last_inner_o = addr_valid_o & inner_last_c;
    assign last_o       = addr_valid_o & inner_last_c & outer_last_c;
    assign done_o       = done_q;

endmodule

// File: tb/tb_nested_addr_counter.sv
// Self-checking bench for nested_addr_counter: vector table, random runs, corner sequences.
module tb_nested_addr_counter;

    localparam int unsigned N = 1024;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, clr_i, addr_ready_i;
    logic [31:0] start_addr_i, inner_count_i, inner_stride_i, outer_count_i, outer_stride_i;
`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
    logic        repeat_i;
`endif
    logic [9:0]  addr_o;
    logic        addr_valid_o, last_inner_o, last_o, busy_o, done_o;

    nested_addr_counter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .clr_i          (clr_i),
        .start_addr_i   (start_addr_i),
        .inner_count_i  (inner_count_i),
        .inner_stride_i (inner_stride_i),
        .outer_count_i  (outer_count_i),
        .outer_stride_i (outer_stride_i),
`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
        .repeat_i       (repeat_i),
`endif
        .addr_o         (addr_o),
        .addr_valid_o   (addr_valid_o),
        .addr_ready_i   (addr_ready_i),
        .last_inner_o   (last_inner_o),
        .last_o         (last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned start, ic, is, oc, os;
        int          mode;      // 0: ready=1, 1: pattern 1,0,0,1, 2: random
        int          exp_n;
        int          exp_last;
    } vec_t;

    typedef struct {
        int unsigned addr;
        bit          li;
        bit          l;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    vec_t  vecs[6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Expected sequence straight from the loop definition
    task automatic build_model(input vec_t v);
        int unsigned ei, eo;
        ei = (v.ic == 0) ? 1 : v.ic;
        eo = (v.oc == 0) ? 1 : v.oc;
        exp_q.delete();
        for (int unsigned o = 0; o < eo; o++) begin
            for (int unsigned i = 0; i < ei; i++) begin
                exp_q.push_back('{(v.start + o * v.os + i * v.is) % N,
                                  i == ei - 1, (i == ei - 1) && (o == eo - 1)});
            end
        end
    endtask

    // Caller is at a negedge; returns at the negedge where done_o shows
    task automatic run_seq(input vec_t v, input bit poke_start);
        bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int    n_xfer = 0;
        int    last_addr = -1;
        int    cyc = 0;
        bit    fin = 0;
        bit    done_seen = 0;
        bit    stalled = 0;
        int    held_addr = 0;
        int    held_li = 0;
        int    held_l = 0;
        bit    rdy;
        beat_t b;
        build_model(v);
        start_addr_i   = v.start;
        inner_count_i  = v.ic;
        inner_stride_i = v.is;
        outer_count_i  = v.oc;
        outer_stride_i = v.os;
        start_i        = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("first_valid", int'(addr_valid_o), 1);
        while (cyc < 500) begin
            cyc++;
            start_i = 1'b0;
            if (fin) begin
                chk("done_pulse", int'(done_o), 1);
                chk("idle_after_done", int'(busy_o), 0);
                done_seen = 1;
                break;
            end
            chk("valid_in_run", int'(addr_valid_o), 1);
            chk("busy_in_run", int'(busy_o), 1);
            chk("no_early_done", int'(done_o), 0);
            if (stalled) begin
                chk("stall_addr", int'(addr_o), held_addr);
                chk("stall_last_inner", int'(last_inner_o), held_li);
                chk("stall_last", int'(last_o), held_l);
            end
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            addr_ready_i = rdy;
            if (poke_start && cyc == 2 && exp_q.size() > 2) begin
                start_i        = 1'b1;
                start_addr_i   = $urandom_range(0, 1023);
                inner_count_i  = $urandom_range(1, 9);
                inner_stride_i = $urandom;
                outer_count_i  = $urandom_range(1, 9);
                outer_stride_i = $urandom;
            end
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_xfer", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("addr", int'(addr_o), int'(b.addr));
                    chk("last_inner", int'(last_inner_o), int'(b.li));
                    chk("last", int'(last_o), int'(b.l));
                    n_xfer++;
                    last_addr = int'(addr_o);
                    if (b.l) fin = 1;
                end
                stalled = 0;
            end else begin
                stalled   = 1;
                held_addr = int'(addr_o);
                held_li   = int'(last_inner_o);
                held_l    = int'(last_o);
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        chk("seq_completed", int'(done_seen), 1);
        chk("n_xfer", n_xfer, v.exp_n);
        chk("last_addr", last_addr, v.exp_last);
    endtask

    initial begin
        vec_t v;
        int unsigned ei, eo;
        vecs[0] = '{4, 3, 1, 2, 8, 0, 6, 14};
        vecs[1] = '{4, 3, 1, 2, 8, 1, 6, 14};
        vecs[2] = '{1022, 4, 1, 1, 0, 0, 4, 1};
        vecs[3] = '{7, 0, 5, 0, 9, 0, 1, 7};
        vecs[4] = '{100, 2, 3, 3, 50, 2, 6, 203};
        vecs[5] = '{1000, 3, 20, 2, 30, 0, 6, 46};

        rst_ni = 1'b0; start_i = 1'b0; clr_i = 1'b0; addr_ready_i = 1'b0;
        start_addr_i = '0; inner_count_i = '0; inner_stride_i = '0;
        outer_count_i = '0; outer_stride_i = '0;
`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
        repeat_i = 1'b0;
`endif
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_addr", int'(addr_o), 0);
        chk("rst_valid", int'(addr_valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_last", int'(last_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Table vectors run back to back: each start lands on the done_o cycle
        for (int t = 0; t < 6; t++) begin
            run_seq(vecs[t], 1'b0);
        end

        // clr_i on the third address with ready high
        start_addr_i = 4; inner_count_i = 3; inner_stride_i = 1;
        outer_count_i = 2; outer_stride_i = 8;
        start_i = 1'b1; addr_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("clr_third_addr", int'(addr_o), 6);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("clr_busy", int'(busy_o), 0);
        chk("clr_valid", int'(addr_valid_o), 0);
        chk("clr_no_done", int'(done_o), 0);
        @(negedge clk_i);
        chk("clr_no_done_late", int'(done_o), 0);
        run_seq(vecs[0], 1'b0);

        // clr_i beats start_i in IDLE
        @(negedge clk_i);
        clr_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0; start_i = 1'b0;
        chk("clr_over_start", int'(busy_o), 0);

        // Asynchronous reset mid-run
        start_i = 1'b1; addr_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(busy_o), 0);
        chk("midrun_rst_addr", int'(addr_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Random configs against the loop model; start_i poked mid-run
        for (int r = 0; r < 20; r++) begin
            v.start = $urandom_range(0, 1023);
            v.ic    = $urandom_range(0, 5);
            v.is    = $urandom_range(0, 1023);
            v.oc    = $urandom_range(0, 4);
            v.os    = $urandom_range(0, 1023);
            v.mode  = 2;
            ei = (v.ic == 0) ? 1 : v.ic;
            eo = (v.oc == 0) ? 1 : v.oc;
            v.exp_n    = int'(ei * eo);
            v.exp_last = int'((v.start + (eo - 1) * v.os + (ei - 1) * v.is) % N);
            run_seq(v, 1'b1);
        end

`ifdef NESTED_ADDR_COUNTER_REPEAT_EN
        @(negedge clk_i);
        repeat_i = 1'b1;
        start_addr_i = 0; inner_count_i = 2; inner_stride_i = 1;
        outer_count_i = 1; outer_stride_i = 0;
        start_i = 1'b1; addr_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rep_addr0", int'(addr_o), 0);
            chk("rep_done_after_1", int'(done_o), (k > 0) ? 1 : 0);
            chk("rep_busy", int'(busy_o), 1);
            @(negedge clk_i);
            chk("rep_addr1", int'(addr_o), 1);
            chk("rep_last", int'(last_o), 1);
            chk("rep_no_done", int'(done_o), 0);
            @(negedge clk_i);
        end
        chk("rep_restart", int'(addr_o), 0);
        chk("rep_done_final", int'(done_o), 1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        chk("rep_clr_busy", int'(busy_o), 0);
        chk("rep_clr_done", int'(done_o), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
